// File: rtl/spi_baud_generator.sv
// SPI baud generator: divides pclk into sclk and produces the one-cycle
// MOSI launch / MISO sample strobes for the selected CPOL/CPHA mode.
module spi_baud_generator #(
    parameter logic [1:0] MODE_RUN  = 2'b00,
    parameter logic [1:0] MODE_WAIT = 2'b01,
    parameter int         DIV_W     = 12
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             ss,
    output logic             sclk,
    output logic             miso_recieve_sclk,
    output logic             miso_recieve_sclk0,
    output logic             mosi_send_sclk,
    output logic             mosi_send_sclk0,
    output logic [DIV_W-1:0] baud_rate_divisor
);

    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] half_m1_s;
    logic [DIV_W-1:0] count_q, count_d;
    logic             sclk_q, sclk_d;
    logic [3:0]       strb_q, strb_d;   // {miso_r, miso_r0, mosi_s, mosi_s0}
    logic             en_s;
    logic             mode_x_s;

    // Divisor (sppr+1) * 2^(spr+1); shift amount widened so spr=7 does not wrap
    always_comb begin
        div_s     = ({{(DIV_W-3){1'b0}}, sppr} + {{(DIV_W-1){1'b0}}, 1'b1})
                    << ({1'b0, spr} + 4'd1);
        half_m1_s = (div_s >> 1) - {{(DIV_W-1){1'b0}}, 1'b1};
        en_s      = !ss && ((spi_mode == MODE_RUN) ||
                            ((spi_mode == MODE_WAIT) && !spiswai));
        mode_x_s  = cpol ^ cpha;
    end

    // Next-state: counter, sclk toggle and edge-qualified strobes
    always_comb begin
        count_d = count_q;
        sclk_d  = sclk_q;
        strb_d  = 4'b0000;
        if (!en_s) begin
            count_d = {DIV_W{1'b0}};
            sclk_d  = cpol;
        end else if (count_q >= half_m1_s) begin
            // >= rather than == so a shrinking divisor still terminates the count
            count_d = {DIV_W{1'b0}};
            sclk_d  = ~sclk_q;
            if (!sclk_q) begin
                strb_d = mode_x_s ? 4'b0001 : 4'b1000;
            end else begin
                strb_d = mode_x_s ? 4'b0100 : 4'b0010;
            end
        end else begin
            count_d = count_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            count_q <= {DIV_W{1'b0}};
            sclk_q  <= 1'b0;
            strb_q  <= 4'b0000;
        end else begin
            count_q <= count_d;
            sclk_q  <= sclk_d;
            strb_q  <= strb_d;
        end
    end

    assign sclk               = sclk_q;
    assign miso_recieve_sclk  = strb_q[3];
    assign miso_recieve_sclk0 = strb_q[2];
    assign mosi_send_sclk     = strb_q[1];
    assign mosi_send_sclk0    = strb_q[0];
    assign baud_rate_divisor  = div_s;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Directed self-checking bench for spi_baud_generator.
module tb_spi_baud_generator;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        cpol;
    logic        cpha;
    logic        ss;
    logic        sclk;
    logic        miso_recieve_sclk;
    logic        miso_recieve_sclk0;
    logic        mosi_send_sclk;
    logic        mosi_send_sclk0;
    logic [11:0] baud_rate_divisor;

    int n_cmp = 0;
    int n_err = 0;
    int rises;

    spi_baud_generator dut (
        .pclk               (pclk),
        .preset_n           (preset_n),
        .spi_mode           (spi_mode),
        .spiswai            (spiswai),
        .sppr               (sppr),
        .spr                (spr),
        .cpol               (cpol),
        .cpha               (cpha),
        .ss                 (ss),
        .sclk               (sclk),
        .miso_recieve_sclk  (miso_recieve_sclk),
        .miso_recieve_sclk0 (miso_recieve_sclk0),
        .mosi_send_sclk     (mosi_send_sclk),
        .mosi_send_sclk0    (mosi_send_sclk0),
        .baud_rate_divisor  (baud_rate_divisor)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {miso_recieve_sclk, miso_recieve_sclk0, mosi_send_sclk, mosi_send_sclk0};
    endfunction

    // Runs n enabled cycles starting from count=0, sclk=pol; checks sclk and strobes each cycle
    task automatic run_cycles(input string tag, input int n, input int half,
                              input logic pol, input logic x, output int nrise);
        int   toggles;
        logic s;
        logic edge_e;
        logic [3:0] exp_st;
        nrise = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            toggles = i / half;
            s       = pol ^ toggles[0];
            edge_e  = (i % half) == 0;
            exp_st  = 4'b0000;
            if (edge_e && s)  exp_st = x ? 4'b0001 : 4'b1000;
            if (edge_e && !s) exp_st = x ? 4'b0100 : 4'b0010;
            chk({tag, "_sclk"}, 12'(sclk), 12'(s));
            chk({tag, "_strb"}, 12'(strobes()), 12'(exp_st));
            if (miso_recieve_sclk || mosi_send_sclk0) nrise++;
        end
    endtask

    initial begin
        preset_n = 1'b0;
        spi_mode = 2'b00;
        spiswai  = 1'b0;
        sppr     = 3'd0;
        spr      = 3'd0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        ss       = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_sclk", 12'(sclk), 12'd0);
        chk("rst_strb", 12'(strobes()), 12'd0);
        preset_n = 1'b1;
        tick();
        chk("idle_sclk", 12'(sclk), 12'd0);

        // 1: minimum divisor
        chk("t1_div", baud_rate_divisor, 12'd2);
        ss = 1'b0;
        run_cycles("t1", 6, 1, 1'b0, 1'b0, rises);

        // 2: divisor 8, 8 rising edges in 64 cycles
        ss = 1'b1;
        tick();
        sppr = 3'd1;
        spr  = 3'd1;
        #1;
        chk("t2_div", baud_rate_divisor, 12'd8);
        ss = 1'b0;
        run_cycles("t2", 64, 4, 1'b0, 1'b0, rises);
        chk("t2_rises", 12'(rises), 12'd8);

        // 3: cpol=1 cpha=0, divisor 4
        ss   = 1'b1;
        cpol = 1'b1;
        spr  = 3'd0;
        tick();
        chk("t3_div", baud_rate_divisor, 12'd4);
        chk("t3_idle", 12'(sclk), 12'd1);
        ss = 1'b0;
        run_cycles("t3", 16, 2, 1'b1, 1'b1, rises);

        // 4: early ss release at divisor 2048
        ss   = 1'b1;
        cpol = 1'b0;
        sppr = 3'd7;
        spr  = 3'd7;
        tick();
        chk("t4_div", baud_rate_divisor, 12'd2048);
        ss = 1'b0;
        run_cycles("t4a", 1500, 1024, 1'b0, 1'b0, rises);
        ss = 1'b1;
        tick();
        chk("t4_rel_sclk", 12'(sclk), 12'd0);
        chk("t4_rel_strb", 12'(strobes()), 12'd0);
        ss = 1'b0;
        run_cycles("t4b", 1030, 1024, 1'b0, 1'b0, rises);

        // 5: low-power gating
        ss   = 1'b1;
        sppr = 3'd0;
        spr  = 3'd1;
        tick();
        spi_mode = 2'b01;
        spiswai  = 1'b1;
        ss       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_wait_sclk", 12'(sclk), 12'd0);
            chk("t5_wait_strb", 12'(strobes()), 12'd0);
        end
        spiswai = 1'b0;
        run_cycles("t5", 6, 2, 1'b0, 1'b0, rises);
        chk("t5_hi", 12'(sclk), 12'd1);
        spi_mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_stop_sclk", 12'(sclk), 12'd0);
            chk("t5_stop_strb", 12'(strobes()), 12'd0);
        end

        // 6: asynchronous reset mid-transfer with sclk high
        ss       = 1'b1;
        spi_mode = 2'b00;
        tick();
        ss = 1'b0;
        run_cycles("t6a", 2, 2, 1'b0, 1'b0, rises);
        chk("t6_pre_sclk", 12'(sclk), 12'd1);
        chk("t6_pre_strb", 12'(strobes()), 12'b1000);
        preset_n = 1'b0;
        #2;
        chk("t6_rst_sclk", 12'(sclk), 12'd0);
        chk("t6_rst_strb", 12'(strobes()), 12'd0);
        tick();
        preset_n = 1'b1;
        run_cycles("t6b", 8, 2, 1'b0, 1'b0, rises);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_baud_generator.md
Name: spi_baud_generator

Overview:
- Generates the SPI serial clock and the per-edge shift/sample strobes consumed directly downstream by shift_register.
- Divides pclk by a programmable divisor taken from the APB control registers (sppr, spr).
- Drives sclk to the pins and qualifies each sclk edge so that shift_register launches MOSI and samples MISO on the correct edge for the selected CPOL/CPHA mode.
- Runs only while a transfer is active (ss low) and the low-power mode permits it.

Parameters:
- MODE_RUN, 2'b00, spi_mode encoding for run.
- MODE_WAIT, 2'b01, spi_mode encoding for wait. Any other value means stop.
- DIV_W, 12, width of the divisor and of the internal counter.

Ports:
- pclk  input  1  system/APB clock; all state changes on its rising edge.
- preset_n  input  1  asynchronous active-low reset.
- spi_mode  input  2  low-power mode from the control/status block.
- spiswai  input  1  1 = stop SPI clocks in wait mode.
- sppr  input  3  baud pre-selection.
- spr  input  3  baud selection.
- cpol  input  1  clock polarity.
- cpha  input  1  clock phase.
- ss  input  1  slave select, active low; 0 = transfer in progress.
- sclk  output  1  serial clock.
- miso_recieve_sclk  output  1  MISO sample strobe, used when cpol^cpha = 0.
- miso_recieve_sclk0  output  1  MISO sample strobe, used when cpol^cpha = 1.
- mosi_send_sclk  output  1  MOSI launch strobe, used when cpol^cpha = 0.
- mosi_send_sclk0  output  1  MOSI launch strobe, used when cpol^cpha = 1.
- baud_rate_divisor  output  12  current divisor value, for status readback.

Behaviour:
- **Reset.** preset_n = 0 asynchronously clears the following: sclk = 0, count = 0, all four strobes = 0.
- **Divisor.** baud_rate_divisor = (sppr+1) * 2^(spr+1), combinational from the live sppr/spr values.
  - Range is 2 to 2048; the value fits in 12 bits without overflow.
  - half = divisor >> 1, range 1 to 1024.
- **Enable.** en = !ss && (spi_mode == MODE_RUN || (spi_mode == MODE_WAIT && !spiswai)).
- **Disabled (en = 0), every pclk:**
  - count <= 0 and sclk <= cpol.
  - All strobes <= 0.
  - The first pclk after reset release therefore sets sclk to the idle level.
- **Enabled (en = 1), every pclk:**
  - If count >= half-1: count <= 0 and sclk <= ~sclk (edge event).
  - Otherwise: count <= count+1 and sclk holds.
  - The >= compare guarantees termination if sppr/spr shrink mid-transfer; the new rate takes effect immediately.
- **Timing.**
  - First sclk edge comes `half` pclk cycles after the first enabled cycle.
  - Thereafter edges occur every `half` cycles, so the sclk period is `divisor` pclk cycles.
- **Strobes.** Registered; asserted for exactly one pclk, coincident with the pclk edge at which sclk toggles (high in the cycle following the toggle edge).
  - Rising edge (sclk 0->1): if cpol^cpha = 0, miso_recieve_sclk = 1; if 1, mosi_send_sclk0 = 1.
  - Falling edge (sclk 1->0): if cpol^cpha = 0, mosi_send_sclk = 1; if 1, miso_recieve_sclk0 = 1.
  - At most one strobe is high in any cycle; the strobes never assert while disabled.
- **cpol/cpha changes** while enabled are not supported mid-byte. sclk follows the new cpol only once disabled. Strobe selection uses the live cpol^cpha.
- **ss rises mid-period:** the next pclk forces sclk = cpol and count = 0, and no strobe fires in that cycle. A subsequent ss fall restarts a full half-period.
- **Reset mid-operation:** immediate clear as above. Recovery then proceeds as for the disabled state.
- **spi_mode change to stop, or to wait with spiswai = 1:** identical to ss rising.

Test Plan:
1. **Minimum divisor.** Reset, then cpol=0 cpha=0 sppr=0 spr=0 ss=0 run.
   - baud_rate_divisor = 2; sclk toggles every pclk.
   - miso_recieve_sclk pulses on each rise and mosi_send_sclk on each fall; the _sclk0 strobes stay 0.
2. **Divisor 8.** sppr=1 spr=1, cpol=0 cpha=0, ss falls.
   - Divisor = 8; first sclk rise is 4 pclk after enable, then the period is 8 pclk.
   - 8 rising edges produce 8 miso_recieve_sclk pulses, each 1 pclk wide.
3. **Mode cpol^cpha = 1.** cpol=1 cpha=0, divisor 4, ss=0.
   - sclk idles at 1 and first falls 2 pclk after enable.
   - miso_recieve_sclk0 pulses on falls and mosi_send_sclk0 on rises; the other two strobes stay 0.
4. **Early ss release.** ss released mid half-period with sppr=7 spr=7 (divisor 2048).
   - Next pclk: sclk = cpol and count = 0, with no strobe.
   - Re-assert ss: first edge 1024 pclk later.
5. **Low-power gating.** spi_mode=01 spiswai=1 while ss=0: sclk frozen at cpol, strobes 0.
   - spiswai -> 0: clocking resumes after a full half-period.
   - spi_mode=10: also frozen.
6. **Reset during operation.** Assert preset_n mid-transfer with sclk=1.
   - sclk, count and strobes go to 0 without waiting for pclk.
   - After release with ss=0, the first edge comes `half` cycles later.
